// File: rtl/spi_display_receiver_if.sv
// Display-link bundle: serial lines from the driver plus the receiver's read port and status.
interface spi_display_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 sclkIn;
    logic                 csIn;
    logic                 mosiIn;
    logic                 dcIn;
    logic [DATA_BITS-1:0] rxData;
    logic                 rxDc;
    logic                 rxValid;
    logic                 rxReady;
    logic                 overflow;
    logic                 frameError;
    logic                 busy;

    modport master (
        output sclkIn, csIn, mosiIn, dcIn, rxReady,
        input  rxData, rxDc, rxValid, overflow, frameError, busy
    );

    modport slave (
        input  sclkIn, csIn, mosiIn, dcIn, rxReady,
        output rxData, rxDc, rxValid, overflow, frameError, busy
    );
endinterface

// File: rtl/spi_display_receiver.sv
// Target-side SPI receiver for the display link: synchronizes the serial lines,
// rebuilds MSB-first words tagged with dc and queues them in a small FWFT FIFO.
module spi_display_receiver #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_display_receiver_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int ENT_W = DATA_BITS + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d, dc_sync_q, dc_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   push_q, push_d;
    logic [ENT_W-1:0]       push_data_q, push_data_d;
    logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic                   valid_q, valid_d, overflow_q, overflow_d;
    logic                   frame_error_q, frame_error_d;
    logic                   sclk_s, cs_s, mosi_s, dc_s, rise_s;
    logic                   pop_s, full_s, wr_s, busy_s;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign dc_s   = dc_sync_q[SYNC_STAGES-1];
    assign rise_s = sclk_s & ~sclk_prev_q;

    // Input synchronizer chains and previous-sclk tap for edge detection
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclkIn};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.csIn};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosiIn};
        dc_sync_d   = {dc_sync_q[SYNC_STAGES-2:0], bus.dcIn};
        sclk_prev_d = sclk_s;
    end

    // FSM next state: cs low opens a frame, cs high closes it
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!cs_s) state_d = S_SHIFT; else state_d = S_IDLE;
            S_SHIFT: if (cs_s)  state_d = S_IDLE;  else state_d = S_SHIFT;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_s = 1'b0;
        case (state_q)
            S_SHIFT: busy_s = 1'b1;
            S_IDLE:  busy_s = 1'b0;
            default: busy_s = 1'b0;
        endcase
    end

    // Word assembly; cs rising takes priority over a coincident sclk edge
    always_comb begin
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        push_d        = 1'b0;
        push_data_d   = push_data_q;
        frame_error_d = frame_error_q;
        case (state_q)
            S_SHIFT: begin
                if (cs_s) begin
                    bit_cnt_d = BIT_ZERO;
                    if (bit_cnt_q != BIT_ZERO) frame_error_d = 1'b1;
                    else                       frame_error_d = frame_error_q;
                end else if (rise_s) begin
                    shift_d = {shift_q[DATA_BITS-2:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d   = BIT_ZERO;
                        push_d      = 1'b1;
                        push_data_d = {dc_s, shift_q[DATA_BITS-2:0], mosi_s};
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            S_IDLE:  bit_cnt_d = BIT_ZERO;
            default: bit_cnt_d = BIT_ZERO;
        endcase
    end

    // FWFT FIFO: a pop frees the slot that a push into a full FIFO needs
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pop_s      = valid_q & bus.rxReady;
        full_s     = (count_q == CNT_FULL);
        wr_s       = push_q & (~full_s | pop_s);
        overflow_d = overflow_q | (push_q & full_s & ~pop_s);
        if (wr_s) begin
            mem_d[wr_ptr_q] = push_data_q;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) rd_ptr_d = rd_ptr_q + PTR_ONE;
        else       rd_ptr_d = rd_ptr_q;
        case ({wr_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        valid_d = (count_d != CNT_ZERO);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Datapath and FIFO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q   <= {SYNC_STAGES{1'b0}};
            cs_sync_q     <= {SYNC_STAGES{1'b1}};
            mosi_sync_q   <= {SYNC_STAGES{1'b0}};
            dc_sync_q     <= {SYNC_STAGES{1'b0}};
            sclk_prev_q   <= 1'b0;
            shift_q       <= {DATA_BITS{1'b0}};
            bit_cnt_q     <= BIT_ZERO;
            push_q        <= 1'b0;
            push_data_q   <= {ENT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= {ENT_W{1'b0}};
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= CNT_ZERO;
            valid_q       <= 1'b0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            dc_sync_q     <= dc_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            push_q        <= push_d;
            push_data_q   <= push_data_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            valid_q       <= valid_d;
            overflow_q    <= overflow_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign bus.rxData     = mem_q[rd_ptr_q][DATA_BITS-1:0];
    assign bus.rxDc       = mem_q[rd_ptr_q][DATA_BITS];
    assign bus.rxValid    = valid_q;
    assign bus.overflow   = overflow_q;
    assign bus.frameError = frame_error_q;
    assign bus.busy       = busy_s;
endmodule

// File: tb/tb_spi_display_receiver.sv
// Bench for spi_display_receiver: directed scenarios plus random frames checked
// against a transaction-level queue model of the received byte stream.
module tb_spi_display_receiver;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [8:0] model_q[$];
    logic       model_ovf;
    logic       model_fe;

    spi_display_receiver_if #(.DATA_BITS(8)) bus ();

    spi_display_receiver #(.DATA_BITS(8), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        bus.sclkIn = 1'b0;
        bus.csIn   = 1'b0;
        repeat (4) tick();
    endtask

    task automatic end_frame();
        bus.sclkIn = 1'b0;
        tick(); tick();
        bus.csIn = 1'b1;
        repeat (4) tick();
    endtask

    // Shifts the top n bits of d; returns right after the last sclk rise.
    task automatic send_bits(input logic [7:0] d, input int n, input logic dc);
        for (int i = 0; i < n; i++) begin
            bus.sclkIn = 1'b0;
            bus.mosiIn = d[7-i];
            bus.dcIn   = dc;
            tick(); tick();
            bus.sclkIn = 1'b1;
            if (i != n - 1) begin
                tick(); tick();
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic dc);
        send_bits(d, 8, dc);
        tick(); tick();
    endtask

    task automatic pop_one();
        bus.rxReady = 1'b1;
        tick();
        bus.rxReady = 1'b0;
    endtask

    task automatic model_push(input logic [8:0] e);
        if (model_q.size() < 4) model_q.push_back(e);
        else                    model_ovf = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.sclkIn = 1'b0; bus.csIn = 1'b1; bus.mosiIn = 1'b0; bus.dcIn = 1'b0; bus.rxReady = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({bus.rxData, bus.rxDc, bus.rxValid, bus.overflow, bus.frameError, bus.busy} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {bus.rxData, bus.rxDc, bus.rxValid, bus.overflow, bus.frameError, bus.busy});
        end
    endtask

    task automatic test_single_byte();
        bus.rxReady = 1'b1;
        start_frame();
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame: got %b required 1", bus.busy); end
        send_bits(8'hA5, 8, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if (bus.rxValid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: clk %0d got %b required 0", k, bus.rxValid); end
        end
        tick();
        n_checks++;
        if ({bus.rxValid, bus.rxDc, bus.rxData} !== {1'b1, 1'b1, 8'hA5}) begin
            n_fail++; $display("FAIL single_latency: got v=%b dc=%b d=%h required v=1 dc=1 d=a5", bus.rxValid, bus.rxDc, bus.rxData);
        end
        tick();
        n_checks++;
        if (bus.rxValid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %b required 0", bus.rxValid); end
        bus.rxReady = 1'b0;
        end_frame();
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_frame: got %b required 0", bus.busy); end
    endtask

    task automatic test_full_pop_push();
        logic [7:0] exp_d;
        start_frame();
        for (int v = 16; v < 20; v++) send_byte(8'(v), 1'b1);
        send_bits(8'h14, 8, 1'b1);
        tick(); tick(); tick();
        bus.rxReady = 1'b1;
        tick();
        bus.rxReady = 1'b0;
        n_checks++;
        if ({bus.overflow, bus.rxData} !== {1'b0, 8'h11}) begin
            n_fail++; $display("FAIL full_pop_push: got ovf=%b head=%h required ovf=0 head=11", bus.overflow, bus.rxData);
        end
        end_frame();
        for (int v = 17; v < 21; v++) begin
            exp_d = 8'(v);
            n_checks++;
            if ({bus.rxValid, bus.rxData} !== {1'b1, exp_d}) begin
                n_fail++; $display("FAIL full_drain: got v=%b d=%h required v=1 d=%h", bus.rxValid, bus.rxData, exp_d);
            end
            pop_one();
        end
        n_checks++;
        if ({bus.rxValid, bus.overflow} !== 2'b00) begin
            n_fail++; $display("FAIL full_end_state: got v=%b ovf=%b required 0 0", bus.rxValid, bus.overflow);
        end
    endtask

    task automatic test_mixed_dc();
        start_frame();
        send_byte(8'hAE, 1'b0);
        send_byte(8'h81, 1'b1);
        end_frame();
        n_checks++;
        if ({bus.rxValid, bus.rxDc, bus.rxData} !== {1'b1, 1'b0, 8'hAE}) begin
            n_fail++; $display("FAIL mixed_first: got v=%b dc=%b d=%h required 1 0 ae", bus.rxValid, bus.rxDc, bus.rxData);
        end
        pop_one();
        n_checks++;
        if ({bus.rxValid, bus.rxDc, bus.rxData} !== {1'b1, 1'b1, 8'h81}) begin
            n_fail++; $display("FAIL mixed_second: got v=%b dc=%b d=%h required 1 1 81", bus.rxValid, bus.rxDc, bus.rxData);
        end
        pop_one();
    endtask

    task automatic test_framing();
        start_frame();
        send_bits(8'hFF, 3, 1'b1);
        tick(); tick();
        end_frame();
        n_checks++;
        if ({bus.rxValid, bus.frameError} !== 2'b01) begin
            n_fail++; $display("FAIL framing_error: got v=%b fe=%b required v=0 fe=1", bus.rxValid, bus.frameError);
        end
        start_frame();
        send_byte(8'h3C, 1'b1);
        end_frame();
        n_checks++;
        if ({bus.rxValid, bus.rxData, bus.frameError} !== {1'b1, 8'h3C, 1'b1}) begin
            n_fail++; $display("FAIL framing_recover: got v=%b d=%h fe=%b required 1 3c 1", bus.rxValid, bus.rxData, bus.frameError);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_d;
        start_frame();
        for (int v = 1; v <= 5; v++) send_byte(8'(v), 1'b1);
        end_frame();
        for (int v = 1; v <= 4; v++) begin
            exp_d = 8'(v);
            n_checks++;
            if ({bus.rxValid, bus.rxData} !== {1'b1, exp_d}) begin
                n_fail++; $display("FAIL overflow_drain: got v=%b d=%h required v=1 d=%h", bus.rxValid, bus.rxData, exp_d);
            end
            pop_one();
        end
        n_checks++;
        if ({bus.rxValid, bus.overflow} !== 2'b01) begin
            n_fail++; $display("FAIL overflow_flag: got v=%b ovf=%b required v=0 ovf=1", bus.rxValid, bus.overflow);
        end
    endtask

    task automatic test_reset_mid_byte();
        start_frame();
        send_bits(8'h5A, 5, 1'b1);
        tick();
        reset = 1'b1; bus.csIn = 1'b1; bus.sclkIn = 1'b0;
        tick();
        n_checks++;
        if ({bus.rxData, bus.rxDc, bus.rxValid, bus.overflow, bus.frameError, bus.busy} !== 13'h0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h required 0", {bus.rxData, bus.rxDc, bus.rxValid, bus.overflow, bus.frameError, bus.busy});
        end
        reset = 1'b0;
        model_q.delete(); model_ovf = 1'b0; model_fe = 1'b0;
        tick(); tick();
        start_frame();
        send_byte(8'hC3, 1'b0);
        end_frame();
        n_checks++;
        if ({bus.rxValid, bus.rxDc, bus.rxData, bus.frameError} !== {1'b1, 1'b0, 8'hC3, 1'b0}) begin
            n_fail++; $display("FAIL mid_reset_next: got v=%b dc=%b d=%h fe=%b required 1 0 c3 0", bus.rxValid, bus.rxDc, bus.rxData, bus.frameError);
        end
        pop_one();
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       dc;
        logic [8:0] exp_e;
        int         nb;
        for (int f = 0; f < 12; f++) begin
            start_frame();
            nb = int'($urandom_range(1, 6));
            for (int b = 0; b < nb; b++) begin
                d  = 8'($urandom);
                dc = 1'($urandom);
                send_byte(d, dc);
                model_push({dc, d});
            end
            if ($urandom_range(0, 3) == 0) begin
                send_bits(8'($urandom), int'($urandom_range(1, 7)), 1'b1);
                tick(); tick();
                model_fe = 1'b1;
            end
            end_frame();
            while (model_q.size() > 0) begin
                exp_e = model_q.pop_front();
                n_checks++;
                if ({bus.rxValid, bus.rxDc, bus.rxData} !== {1'b1, exp_e}) begin
                    n_fail++; $display("FAIL random_data: frame %0d got v=%b e=%h required v=1 e=%h", f, bus.rxValid, {bus.rxDc, bus.rxData}, exp_e);
                end
                pop_one();
            end
            n_checks++;
            if ({bus.rxValid, bus.overflow, bus.frameError} !== {1'b0, model_ovf, model_fe}) begin
                n_fail++; $display("FAIL random_flags: frame %0d got v=%b ovf=%b fe=%b required 0 %b %b",
                                   f, bus.rxValid, bus.overflow, bus.frameError, model_ovf, model_fe);
            end
        end
    endtask

    initial begin
        model_ovf = 1'b0;
        model_fe  = 1'b0;
        test_reset();
        test_single_byte();
        test_full_pop_push();
        test_mixed_dc();
        test_framing();
        test_overflow();
        test_reset_mid_byte();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
